uart_axil_regs: RTL

AXI4-Lite register slave placed directly upstream of `uart_top`. It turns CPU register accesses into the `tx_start`/`tx_data`/`prescale` controls of the UART core. It also captures each received byte from `rx_data`/`rx_ready` into a readable holding register with status and overrun flags. One instance sits between the system interconnect and one `uart_top`.

---
 rtl/uart_axil_if.sv | 30 +++
 rtl/uart_axil_regs.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_axil_if.sv
// AXI4-Lite bus bundle for the UART register block (4-bit byte address, 32-bit data).
interface uart_axil_if;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/uart_axil_regs.sv
// AXI4-Lite register front end for uart_top: TX launch FSM, RX holding register,
// sticky overrun flags and the baud prescale register.
module uart_axil_regs #(
    parameter int unsigned PRESCALE_RESET = 868
) (
    input  logic        clk,
    input  logic        rst,
    uart_axil_if.slave  s_axil,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    input  logic        rx_busy,
    output logic [15:0] prescale
);
    localparam logic [15:0] PRESCALE_INIT = 16'(PRESCALE_RESET);
    localparam logic [1:0]  ADDR_TXDATA   = 2'd0;
    localparam logic [1:0]  ADDR_RXDATA   = 2'd1;
    localparam logic [1:0]  ADDR_STATUS   = 2'd2;
    localparam logic [1:0]  ADDR_PRESCALE = 2'd3;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_ACTIVE} tx_state_t;

    tx_state_t   tx_state_reg, tx_state_next;
    logic        aw_held_reg, w_held_reg, bvalid_reg, awready_reg, wready_reg;
    logic        aw_held_next, w_held_next, bvalid_next;
    logic [1:0]  awaddr_reg;
    logic [15:0] wdata_reg;
    logic [1:0]  wstrb_reg;
    logic        arready_reg, rvalid_reg, rvalid_next;
    logic [31:0] rdata_reg, rd_mux;
    logic [7:0]  tx_data_reg, rx_hold_reg;
    logic        rx_valid_reg, rx_overrun_reg, tx_overrun_reg;
    logic [15:0] prescale_reg, prescale_merge;
    logic [4:0]  status;

    logic aw_hs, w_hs, do_write, ar_hs, pop;
    logic wr_tx, wr_status, wr_prescale, tx_accept;
    logic unused_bits;

    assign aw_hs       = s_axil.awvalid && awready_reg;
    assign w_hs        = s_axil.wvalid && wready_reg;
    assign do_write    = aw_held_reg && w_held_reg;
    assign ar_hs       = s_axil.arvalid && arready_reg;
    assign pop         = ar_hs && (s_axil.araddr[3:2] == ADDR_RXDATA);
    assign wr_tx       = do_write && (awaddr_reg == ADDR_TXDATA) && wstrb_reg[0];
    assign wr_status   = do_write && (awaddr_reg == ADDR_STATUS) && wstrb_reg[0];
    assign wr_prescale = do_write && (awaddr_reg == ADDR_PRESCALE);
    assign tx_accept   = wr_tx && (tx_state_reg == TX_IDLE);

    assign status = {rx_busy, tx_overrun_reg, rx_overrun_reg, rx_valid_reg,
                     (tx_state_reg != TX_IDLE) || tx_busy};

    assign s_axil.awready = awready_reg;
    assign s_axil.wready  = wready_reg;
    assign s_axil.bvalid  = bvalid_reg;
    assign s_axil.bresp   = 2'b00;
    assign s_axil.arready = arready_reg;
    assign s_axil.rvalid  = rvalid_reg;
    assign s_axil.rdata   = rdata_reg;
    assign s_axil.rresp   = 2'b00;
    assign tx_data        = tx_data_reg;
    assign prescale       = prescale_reg;

    assign unused_bits = ^{s_axil.awaddr[1:0], s_axil.araddr[1:0],
                           s_axil.wdata[31:16], s_axil.wstrb[3:2]};

    // Write-channel bookkeeping: each beat is held until both arrive, then a response is issued
    always_comb begin
        aw_held_next = aw_held_reg;
        w_held_next  = w_held_reg;
        bvalid_next  = bvalid_reg;
        if (aw_hs)                         aw_held_next = 1'b1;
        if (w_hs)                          w_held_next  = 1'b1;
        if (bvalid_reg && s_axil.bready)   bvalid_next  = 1'b0;
        if (do_write) begin
            aw_held_next = 1'b0;
            w_held_next  = 1'b0;
            bvalid_next  = 1'b1;
        end
    end

    // Registered write channel; readies are registered so they read 0 while in reset
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            awaddr_reg  <= 2'b0;
            wdata_reg   <= 16'b0;
            wstrb_reg   <= 2'b0;
        end else begin
            aw_held_reg <= aw_held_next;
            w_held_reg  <= w_held_next;
            bvalid_reg  <= bvalid_next;
            awready_reg <= !bvalid_next && !aw_held_next;
            wready_reg  <= !bvalid_next && !w_held_next;
            if (aw_hs) awaddr_reg <= s_axil.awaddr[3:2];
            if (w_hs) begin
                wdata_reg <= s_axil.wdata[15:0];
                wstrb_reg <= s_axil.wstrb[1:0];
            end
        end
    end

    // TX FSM state register
    always_ff @(posedge clk) begin
        if (rst) tx_state_reg <= TX_IDLE;
        else     tx_state_reg <= tx_state_next;
    end

    // TX FSM next state: START lasts one cycle, ACTIVE waits for the core to go idle
    always_comb begin
        tx_state_next = tx_state_reg;
        case (tx_state_reg)
            TX_IDLE:   if (tx_accept) tx_state_next = TX_START;
            TX_START:  tx_state_next = TX_ACTIVE;
            TX_ACTIVE: if (!tx_busy) tx_state_next = TX_IDLE;
            default:   tx_state_next = TX_IDLE;
        endcase
    end

    // TX FSM outputs
    always_comb begin
        tx_start = (tx_state_reg == TX_START);
    end

    // Transmit byte latch; dropped writes leave it untouched
    always_ff @(posedge clk) begin
        if (rst)            tx_data_reg <= 8'b0;
        else if (tx_accept) tx_data_reg <= wdata_reg[7:0];
    end

    // Per-byte-lane merge of a PRESCALE write with the current value
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_prescale_lane
            assign prescale_merge[gi*8 +: 8] = wstrb_reg[gi] ? wdata_reg[gi*8 +: 8]
                                                             : prescale_reg[gi*8 +: 8];
        end
    endgenerate

    // Prescale register; a write that would leave it 0 is ignored
    always_ff @(posedge clk) begin
        if (rst)                                        prescale_reg <= PRESCALE_INIT;
        else if (wr_prescale && prescale_merge != 16'd0) prescale_reg <= prescale_merge;
    end

    // RX holding register: a new byte always wins over a pop in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_hold_reg  <= 8'b0;
            rx_valid_reg <= 1'b0;
        end else if (rx_ready) begin
            rx_hold_reg  <= rx_data;
            rx_valid_reg <= 1'b1;
        end else if (pop) begin
            rx_valid_reg <= 1'b0;
        end
    end

    // Sticky overrun flags, write-1-to-clear; a coincident set takes priority
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_overrun_reg <= 1'b0;
            tx_overrun_reg <= 1'b0;
        end else begin
            if (rx_ready && rx_valid_reg && !pop)  rx_overrun_reg <= 1'b1;
            else if (wr_status && wdata_reg[2])    rx_overrun_reg <= 1'b0;
            if (wr_tx && tx_state_reg != TX_IDLE)  tx_overrun_reg <= 1'b1;
            else if (wr_status && wdata_reg[3])    tx_overrun_reg <= 1'b0;
        end
    end

    // Read data selection from the current register state
    always_comb begin
        rd_mux = 32'b0;
        case (s_axil.araddr[3:2])
            ADDR_RXDATA:   rd_mux = {24'b0, rx_hold_reg};
            ADDR_STATUS:   rd_mux = {27'b0, status};
            ADDR_PRESCALE: rd_mux = {16'b0, prescale_reg};
            default:       rd_mux = 32'b0;
        endcase
    end

    // Read-valid next state: set by an AR handshake, cleared by rready
    always_comb begin
        rvalid_next = rvalid_reg;
        if (rvalid_reg && s_axil.rready) rvalid_next = 1'b0;
        if (ar_hs)                       rvalid_next = 1'b1;
    end

    // Registered read channel
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_reg  <= 1'b0;
            arready_reg <= 1'b0;
            rdata_reg   <= 32'b0;
        end else begin
            rvalid_reg  <= rvalid_next;
            arready_reg <= !rvalid_next;
            if (ar_hs) rdata_reg <= rd_mux;
        end
    end
endmodule
